mbr_ctrl: RTL and testbench

- Parametrised memory buffer register with an integrated memory-transaction controller.
- Holds one DATA_W-bit data word, loads it from memory or the ALU, and writes it back to memory over a req/ack handshake.
- Adds busy/done/error status and an ack timeout.
- Sits between the datapath (ALU, control unit) and the memory interface.

---
 rtl/mbr_pkg.sv | 17 +
 rtl/mbr_timeout_cnt.sv | 42 ++++
 rtl/mbr_ctrl.sv | 153 +++++++++++++++
 tb/tb_mbr_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mbr_pkg.sv
// mbr_pkg: shared types and helpers for the memory buffer register controller.
//   state_e   - controller FSM states
//   tmo_cnt_w - width of the ack-timeout counter for a given TIMEOUT_CYC
package mbr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_e;

  // clog2(TIMEOUT_CYC+1), never below 1 so a disabled timeout still has a legal width.
  function automatic int tmo_cnt_w(input int tmo);
    return (tmo < 1) ? 1 : $clog2(tmo + 1);
  endfunction

endpackage

// File: rtl/mbr_timeout_cnt.sv
// mbr_timeout_cnt: saturating wait-cycle counter for the memory ack timeout.
//   clk, rst_n - clock, async active-low reset
//   clr        - restart the count (transaction start)
//   en         - a wait cycle is in progress
//   expired    - the current wait cycle is the TIMEOUT_CYC-th one
// TIMEOUT_CYC = 0 disables the timeout: expired is tied low and no counter exists.
module mbr_timeout_cnt
  import mbr_pkg::*;
#(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = tmo_cnt_w(TIMEOUT_CYC);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      logic unused;
      assign unused  = ^{clk, rst_n, clr, en};
      assign expired = 1'b0;
    end else begin : g_on
      // cnt_q holds the number of completed wait cycles, so the current cycle is
      // the last allowed one when cnt_q == TIMEOUT_CYC-1.
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   cnt_q <= '0;
        else if (clr)                 cnt_q <= '0;
        else if (en && cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
      end

      assign expired = en && (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/mbr_ctrl.sv
// mbr_ctrl: memory buffer register with an integrated read/write transaction
// controller (req/ack handshake, busy/done/err status, ack timeout).
//   clk, rst_n            - clock, async active-low reset
//   rd_start / wr_start   - start a memory read into / write from the MBR
//   alu_load, alu_data    - load the MBR from the ALU (IDLE only)
//   addr_in               - transaction address, sampled on start
//   mbr_data              - MBR contents
//   busy / done / err     - transaction outstanding / completion pulse / failure pulse
//   mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack - memory interface
// Optional: define MBR_PARITY_EN to add mem_wpar (even parity of mem_wdata) and
// mem_rpar (checked against mem_rdata on read ack; mismatch -> err, MBR kept).
module mbr_ctrl
  import mbr_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_start,
  input  logic              wr_start,
  input  logic              alu_load,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] alu_data,
  output logic [DATA_W-1:0] mbr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef MBR_PARITY_EN
 ,output logic              mem_wpar
 ,input  logic              mem_rpar
`endif
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mbr_q, mbr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              tmo_clr, tmo_exp, rd_ok;

`ifdef MBR_PARITY_EN
  assign rd_ok    = ((^mem_rdata) == mem_rpar);
  assign mem_wpar = ^wdata_q;
`else
  assign rd_ok    = 1'b1;
`endif

  mbr_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmo_clr),
    .en      (state_q != IDLE),
    .expired (tmo_exp)
  );

  always_comb begin
    state_d = state_q;
    mbr_d   = mbr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    req_d   = req_q;
    we_d    = we_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    tmo_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_start) begin
          addr_d  = addr_in;
          req_d   = 1'b1;
          we_d    = 1'b0;
          tmo_clr = 1'b1;
          state_d = RD_WAIT;
        end else if (wr_start) begin
          addr_d  = addr_in;
          wdata_d = mbr_q;
          req_d   = 1'b1;
          we_d    = 1'b1;
          tmo_clr = 1'b1;
          state_d = WR_WAIT;
        end else if (alu_load) begin
          mbr_d = alu_data;
        end
      end
      RD_WAIT, WR_WAIT: begin
        // Ack wins over a timeout expiring at the same edge.
        if (mem_ack || tmo_exp) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = IDLE;
          if (!mem_ack) begin
            err_d = 1'b1;
          end else if (state_q == WR_WAIT) begin
            done_d = 1'b1;
          end else if (rd_ok) begin
            mbr_d  = mem_rdata;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        req_d   = 1'b0;
        we_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mbr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mbr_q   <= mbr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mbr_data  = mbr_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mbr_ctrl.sv
module tb_mbr_ctrl;

  localparam int DW = 16;
  localparam int AW = 8;

  typedef struct {
    bit          is_err;
    logic [DW-1:0] mbr;
  } sb_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_start = 0, wr_start = 0, alu_load = 0, mem_ack = 0;
  logic [AW-1:0] addr_in = '0;
  logic [DW-1:0] alu_data = '0, mem_rdata = '0;
  logic [DW-1:0] mbr_data, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          busy, done, err, mem_req, mem_we;

  logic          rd0 = 0;
  logic [DW-1:0] mbr0, wdata0;
  logic [AW-1:0] addr0;
  logic          busy0, done0, err0, req0, we0;

`ifdef MBR_PARITY_EN
  logic mem_wpar, mem_rpar = 1'b0, wpar0;
`endif

  int  n_chk = 0;
  int  n_err = 0;
  sb_t sb[$];

  always #5 clk = ~clk;

  mbr_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .rst_n(rst_n), .rd_start(rd_start), .wr_start(wr_start),
    .alu_load(alu_load), .addr_in(addr_in), .alu_data(alu_data),
    .mbr_data(mbr_data), .busy(busy), .done(done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef MBR_PARITY_EN
   ,.mem_wpar(mem_wpar), .mem_rpar(mem_rpar)
`endif
  );

  mbr_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rd_start(rd0), .wr_start(1'b0),
    .alu_load(1'b0), .addr_in(8'h5A), .alu_data(16'h0),
    .mbr_data(mbr0), .busy(busy0), .done(done0), .err(err0),
    .mem_req(req0), .mem_we(we0), .mem_addr(addr0),
    .mem_wdata(wdata0), .mem_rdata(16'h0), .mem_ack(1'b0)
`ifdef MBR_PARITY_EN
   ,.mem_wpar(wpar0), .mem_rpar(1'b0)
`endif
  );

  task automatic fail(input string tag);
    n_err++;
    $error("FAIL %s", tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_end(input int max, output int cyc);
    bit  seen = 0;
    sb_t e;
    cyc = 0;
    for (int c = 1; c <= max && !seen; c++) begin
      step();
      cyc = c;
      if (done || err) seen = 1;
    end
    n_chk++; if (seen !== 1'b1) fail("end_seen");
    n_chk++; if (sb.size() == 0) fail("sb_nonempty");
    if (seen && sb.size() != 0) begin
      e = sb.pop_front();
      n_chk++; if (err !== e.is_err) fail("end_err");
      n_chk++; if (done !== !e.is_err) fail("end_done");
      n_chk++; if (mbr_data !== e.mbr) fail("end_mbr");
      n_chk++; if (busy !== 1'b0) fail("end_busy");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    bit flag;

    repeat (2) step();
    n_chk++; if (mbr_data !== 16'h0) fail("rst_mbr");
    n_chk++; if (busy !== 1'b0) fail("rst_busy");
    n_chk++; if (mem_req !== 1'b0) fail("rst_req");
    n_chk++; if (done !== 1'b0) fail("rst_done");
    n_chk++; if (err !== 1'b0) fail("rst_err");
    rst_n = 1'b1;
    step();

    rd_start = 1; addr_in = 8'h3C;
    step();
    rd_start = 0;
    n_chk++; if (mem_req !== 1'b1) fail("rd_req");
    n_chk++; if (mem_we !== 1'b0) fail("rd_we");
    n_chk++; if (mem_addr !== 8'h3C) fail("rd_addr");
    n_chk++; if (busy !== 1'b1) fail("rd_busy");
    mem_ack = 1; mem_rdata = 16'hBEEF;
    sb.push_back('{1'b0, 16'hBEEF});
    wait_end(20, cyc);
    mem_ack = 0;
    n_chk++; if (cyc != 1) fail("rd_lat");
    step();
    n_chk++; if (done !== 1'b0) fail("rd_done_1cyc");

    mem_ack = 1; mem_rdata = 16'h4321;
    step();
    mem_ack = 0;
    n_chk++; if (mbr_data !== 16'hBEEF) fail("idle_ack_mbr");
    n_chk++; if (done !== 1'b0) fail("idle_ack_done");

    rd_start = 1; addr_in = 8'h11;
    step();
    rd_start = 0;
    n_chk++; if (busy !== 1'b1) fail("mid_busy");
    rst_n = 0;
    #1;
    n_chk++; if (mbr_data !== 16'h0) fail("mid_rst_mbr");
    n_chk++; if (mem_req !== 1'b0) fail("mid_rst_req");
    n_chk++; if (busy !== 1'b0) fail("mid_rst_busy");
    step();
    rst_n = 1;
    flag = 0;
    repeat (4) begin step(); if (done || err) flag = 1; end
    n_chk++; if (flag !== 1'b0) fail("mid_rst_nopulse");

    alu_load = 1; alu_data = 16'h1234;
    step();
    alu_load = 0; alu_data = 16'hDEAD;
    n_chk++; if (mbr_data !== 16'h1234) fail("alu_mbr");
    n_chk++; if (done !== 1'b0) fail("alu_nodone");
    wr_start = 1; addr_in = 8'h10;
    step();
    wr_start = 0;
    n_chk++; if (mem_we !== 1'b1) fail("wr_we");
    n_chk++; if (mem_addr !== 8'h10) fail("wr_addr");
    flag = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem_wdata !== 16'h1234 || !busy || done) flag = 1;
      step();
    end
    n_chk++; if (flag !== 1'b0) fail("wr_wdata_stable");
    n_chk++; if (mem_wdata !== 16'h1234) fail("wr_wdata");
    mem_ack = 1; mem_rdata = 16'hFFFF;
    sb.push_back('{1'b0, 16'h1234});
    wait_end(20, cyc);
    mem_ack = 0;
    n_chk++; if (cyc != 1) fail("wr_lat");
    step();
    n_chk++; if (done !== 1'b0) fail("wr_done_once");

    rd_start = 1; wr_start = 1; alu_load = 1; alu_data = 16'hFFFF; addr_in = 8'h22;
    step();
    rd_start = 0; wr_start = 0; alu_load = 0;
    n_chk++; if (mem_we !== 1'b0) fail("pri_we");
    n_chk++; if (mbr_data !== 16'h1234) fail("pri_mbr");
    n_chk++; if (mem_addr !== 8'h22) fail("pri_addr");
    rd_start = 1; addr_in = 8'h55;
    step();
    rd_start = 0;
    n_chk++; if (mem_addr !== 8'h22) fail("ign_addr");
    n_chk++; if (busy !== 1'b1) fail("ign_busy");
    mem_ack = 1; mem_rdata = 16'hA5A5;
    sb.push_back('{1'b0, 16'hA5A5});
    wait_end(20, cyc);
    mem_ack = 0;

    rd_start = 1; addr_in = 8'h40; mem_rdata = 16'h9999;
    step();
    rd_start = 0;
    sb.push_back('{1'b1, 16'hA5A5});
    wait_end(40, cyc);
    n_chk++; if (cyc != 15) fail("tmo_lat");
    n_chk++; if (mem_req !== 1'b0) fail("tmo_req");

    rd_start = 1; addr_in = 8'h41;
    step();
    rd_start = 0;
    repeat (14) step();
    n_chk++; if (busy !== 1'b1) fail("exp_busy");
    mem_ack = 1; mem_rdata = 16'h7777;
    sb.push_back('{1'b0, 16'h7777});
    wait_end(5, cyc);
    mem_ack = 0;
    n_chk++; if (cyc != 1) fail("exp_lat");

    wr_start = 1; addr_in = 8'h77;
    step();
    wr_start = 0;
    n_chk++; if (busy !== 1'b1) fail("b2b_busy");
    n_chk++; if (mem_we !== 1'b1) fail("b2b_we");
    n_chk++; if (mem_wdata !== 16'h7777) fail("b2b_wdata");
    mem_ack = 1;
    sb.push_back('{1'b0, 16'h7777});
    wait_end(5, cyc);
    mem_ack = 0;

    rd0 = 1;
    step();
    rd0 = 0;
    flag = 0;
    repeat (100) begin step(); if (err0) flag = 1; end
    n_chk++; if (flag !== 1'b0) fail("notmo_err");
    n_chk++; if (busy0 !== 1'b1) fail("notmo_busy");

`ifdef MBR_PARITY_EN
    rd_start = 1; addr_in = 8'h01;
    step();
    rd_start = 0;
    mem_ack = 1; mem_rdata = 16'h0001; mem_rpar = 0;
    sb.push_back('{1'b1, 16'h7777});
    wait_end(5, cyc);
    mem_ack = 0;
    rd_start = 1;
    step();
    rd_start = 0;
    mem_ack = 1; mem_rdata = 16'h0001; mem_rpar = 1;
    sb.push_back('{1'b0, 16'h0001});
    wait_end(5, cyc);
    mem_ack = 0;
    alu_load = 1; alu_data = 16'h0003;
    step();
    alu_load = 0;
    wr_start = 1;
    step();
    wr_start = 0;
    n_chk++; if (mem_wpar !== 1'b0) fail("wpar_3");
    mem_ack = 1;
    sb.push_back('{1'b0, 16'h0003});
    wait_end(5, cyc);
    mem_ack = 0;
`endif

    n_chk++; if (sb.size() != 0) fail("sb_drained");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
